// File: rtl/div.sv
// Iterative 32-bit restoring divider (one quotient bit per clock) with a start/ready handshake.
// Optional signed support is built only when DIV_SIGNED_EN is defined; otherwise every divide is unsigned.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W);

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BYZERO = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [W-1:0]     dvs_q, dvs_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             ready_q, ready_d;

    logic [W-1:0]     op1_mag, op2_mag;
    logic [W-1:0]     quot_fix, rem_fix;
    logic [W:0]       trial, diff;
    logic             ge;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign op1_mag  = (signed_div_i && opdata1_i[W-1]) ? W'(-opdata1_i) : opdata1_i;
    assign op2_mag  = (signed_div_i && opdata2_i[W-1]) ? W'(-opdata2_i) : opdata2_i;
    assign quot_fix = neg_quot_q ? W'(-dvd_q) : dvd_q;
    assign rem_fix  = neg_rem_q  ? W'(-rem_q) : rem_q;
`else
    logic signed_unused;

    assign signed_unused = signed_div_i;
    assign op1_mag       = opdata1_i;
    assign op2_mag       = opdata2_i;
    assign quot_fix      = dvd_q;
    assign rem_fix       = rem_q;
`endif

    // One restoring step: shift in the next dividend bit and try to subtract the divisor.
    assign trial = {rem_q, dvd_q[W-1]};
    assign ge    = (trial >= {1'b0, dvs_q});
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            ST_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    dvd_d = op1_mag;
                    dvs_d = op2_mag;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef DIV_SIGNED_EN
                    neg_quot_d = signed_div_i && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                    neg_rem_d  = signed_div_i && opdata1_i[W-1];
`endif
                    state_d = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_FREE;
                end else if (cnt_q != CNT_LAST) begin
                    rem_d = ge ? diff[W-1:0] : trial[W-1:0];
                    dvd_d = {dvd_q[W-2:0], ge};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                // Result is held for as long as the requester keeps start asserted.
                if (!start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = ST_FREE;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the iterative divider; expected values are hand-computed.
// Signed expectations switch on DIV_SIGNED_EN to match the build under test.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int tests = 0;
    int fails = 0;

`ifdef DIV_SIGNED_EN
    localparam logic [63:0] EXP_M7_2      = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    localparam logic [63:0] EXP_7_M2      = {32'h0000_0001, 32'hFFFF_FFFD};
    localparam logic [63:0] EXP_MIN_M1    = {32'h0000_0000, 32'h8000_0000};
`else
    localparam logic [63:0] EXP_M7_2      = {32'h0000_0001, 32'h7FFF_FFFC};
    localparam logic [63:0] EXP_7_M2      = {32'h0000_0007, 32'h0000_0000};
    localparam logic [63:0] EXP_MIN_M1    = {32'h8000_0000, 32'h0000_0000};
`endif

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Full handshake: accept, count edges to ready, check result and hold, then drop start.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        op1 = $urandom;
        op2 = $urandom;
        n   = 0;
        while (!ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result, exp);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " ready held"}, 64'(ready), 64'd1);
        check({tag, " result held"}, result, exp);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ready drop"}, 64'(ready), 64'd0);
        check({tag, " result drop"}, result, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic rose;
        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("udiv ffffffff/10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 33);
        run_div("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, EXP_M7_2, 33);
        run_div("sdiv 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, EXP_7_M2, 33);
        run_div("sdiv min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, EXP_MIN_M1, 33);
        run_div("udiv -7/2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h0000_0001, 32'h7FFF_FFFC}, 33);
        run_div("udiv 5/9", 1'b0, 32'h5, 32'h9, {32'h0000_0005, 32'h0000_0000}, 33);
        run_div("divzero 123/0", 1'b0, 32'd123, 32'h0, 64'd0, 1);

        // Annul at iteration 10; the aborted divide must never raise ready.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd100;
        op2        = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check("annul ready", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        rose  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) rose = 1'b1;
        end
        check("annul ready never", 64'(rose), 64'd0);
        run_div("after annul 100/3", 1'b0, 32'd100, 32'd3, {32'h1, 32'h21}, 33);

        // Reset in the middle of an operation.
        @(negedge clk);
        op1   = 32'hFFFF_FFFF;
        op2   = 32'h10;
        start = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop reset ready", 64'(ready), 64'd0);
        check("midop reset result", result, 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        run_div("after reset 9/4", 1'b0, 32'd9, 32'd4, {32'h1, 32'h2}, 33);

        // Reset while a result is being held clears it immediately.
        @(negedge clk);
        op1   = 32'd9;
        op2   = 32'd4;
        start = 1'b1;
        repeat (36) @(posedge clk);
        #1;
        check("end hold result", result, {32'h1, 32'h2});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("end reset ready", 64'(ready), 64'd0);
        check("end reset result", result, 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;

        // Back-to-back with exactly one idle cycle between requests.
        run_div("b2b 100/7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
        run_div("b2b ffffffff/1", 1'b0, 32'hFFFF_FFFF, 32'h1, {32'h0, 32'hFFFF_FFFF}, 33);
        run_div("b2b -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, EXP_M7_2, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
